pe_result_drain: RTL

PE_RESULT_DRAIN -- requirements
Module: pe_result_drain

---
 rtl/pe_result_drain_if.sv | 28 ++
 rtl/pe_result_drain.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pe_result_drain_if.sv
// Output word stream of the PE result drain.
//   out_valid : word on out_data/out_addr is valid (master -> slave)
//   out_ready : slave accepts the word this cycle     (slave -> master)
//   out_data  : packed or raw output word             (master -> slave)
//   out_addr  : word index within the current drain   (master -> slave)
interface pe_result_drain_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    output out_ready
  );
endinterface

// File: rtl/pe_result_drain.sv
// Captures the systolic-array result matrix on start and streams it out word by word, either
// one raw accumulator per word or NUM_COMPUTE_LANES shifted-and-saturated lanes per word.
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle capture/drain request (honoured only when idle)
//   quant_en    : 0 = raw words, 1 = packed requantized words
//   shift       : arithmetic right shift applied before saturation in packed mode
//   results_arr : row-major result matrix
//   drain       : output word stream (valid/ready, data, addr)
//   busy        : drain in progress
//   done        : one-cycle pulse after the final transfer
// BUFFER_WORD_SIZE must equal ACCUMULATOR_DATA_WIDTH.
module pe_result_drain #(
  parameter int unsigned ARRAY_SIZE             = 8,
  parameter int unsigned COMPUTE_DATA_WIDTH     = 4,
  parameter int unsigned ACCUMULATOR_DATA_WIDTH = 16,
  parameter int unsigned BUFFER_WORD_SIZE       = 16,
  parameter int unsigned NUM_COMPUTE_LANES      = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     quant_en,
  input  logic                               [3:0] shift,
  input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] results_arr [ARRAY_SIZE*ARRAY_SIZE],
  pe_result_drain_if.master                        drain,
  output logic                                     busy,
  output logic                                     done
);

  localparam int unsigned NumElems  = ARRAY_SIZE * ARRAY_SIZE;
  localparam int unsigned AddrWidth = $clog2(NumElems);
  localparam int unsigned Cw        = COMPUTE_DATA_WIDTH;
  localparam int unsigned Aw        = ACCUMULATOR_DATA_WIDTH;

  localparam logic [AddrWidth-1:0] LastRaw    = AddrWidth'(NumElems - 1);
  localparam logic [AddrWidth-1:0] LastPacked = AddrWidth'(NumElems / NUM_COMPUTE_LANES - 1);

  localparam logic signed [Aw-1:0] LaneMax = Aw'((2 ** (Cw - 1)) - 1);
  localparam logic signed [Aw-1:0] LaneMin = Aw'(-(2 ** (Cw - 1)));

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e state_q, state_d;

  logic signed [Aw-1:0]        snap_q [NumElems];
  logic                        quant_q;
  logic [3:0]                  shift_q;
  logic [AddrWidth-1:0]        addr_q, addr_d;
  logic [AddrWidth-1:0]        last_addr;
  logic [AddrWidth-1:0]        lane_idx;
  logic [BUFFER_WORD_SIZE-1:0] word;
  logic                        capture;

  // Clamp a shifted accumulator to the signed lane range.
  function automatic logic [Cw-1:0] sat_lane(input logic signed [Aw-1:0] v);
    if (v > LaneMax) begin
      return LaneMax[Cw-1:0];
    end else if (v < LaneMin) begin
      return LaneMin[Cw-1:0];
    end
    return v[Cw-1:0];
  endfunction

  assign capture   = (state_q == StIdle) && start;
  assign last_addr = quant_q ? LastPacked : LastRaw;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Snapshot is only rewritten by an accepted start, so later changes on the inputs are invisible.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      snap_q  <= results_arr;
      quant_q <= quant_en;
      shift_q <= shift;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStream;
          addr_d  = '0;
        end
      end
      StStream: begin
        // out_valid is always high here, so ready alone marks a transfer.
        if (drain.out_ready) begin
          addr_d = addr_q + 1'b1;
          if (addr_q == last_addr) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Word assembly from the snapshot at the current address
  always_comb begin
    word     = '0;
    lane_idx = '0;
    if (quant_q) begin
      for (int unsigned l = 0; l < NUM_COMPUTE_LANES; l++) begin
        lane_idx            = AddrWidth'(addr_q * NUM_COMPUTE_LANES + l);
        word[l*Cw +: Cw]    = sat_lane(snap_q[lane_idx] >>> shift_q);
      end
    end else begin
      word = BUFFER_WORD_SIZE'(snap_q[addr_q]);
    end
  end

  // Outputs; gated by rst so they read zero for the whole reset interval.
  always_comb begin
    drain.out_valid = 1'b0;
    drain.out_data  = '0;
    drain.out_addr  = '0;
    busy            = 1'b0;
    done            = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StStream: begin
          drain.out_valid = 1'b1;
          drain.out_data  = word;
          drain.out_addr  = addr_q;
          busy            = 1'b1;
        end
        StDone:  done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
